control_sequencer: RTL
======================

# control_sequencer

Hardwired control unit for the mini CPU. It drives the control inputs of `data_path` that benches currently toggle by hand: register in/out enables, memory read, Y/Z/HI/LO loads and the ALU `op` code. It runs a fixed T-state sequence: fetch, then decode of the instruction latched in IR, then execute of register-register ALU and MUL/DIV instructions. It sits beside `data_path`, sees only the IR contents and a `run` input, and owns no datapath storage.

## Interface
- Parameters: none. Encodings live in the shared package.
- `Clock` in 1: single system clock; all state changes on the rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `run` in 1: start/resume request.
- `IR` in 32: instruction register contents from `data_path`.
  - `[31:27]` opcode, `[26:23]` ra, `[22:19]` rb, `[18:15]` rc.
- `PCout`, `Zhighout`, `Zlowout`, `MDRout`, `HIout`, `LOout` out 1 each: bus source enables.
- `MARin`, `PCin`, `MDRin`, `IRin`, `Yin`, `ZHighin`, `Zlowin`, `HIin`, `LOin` out 1 each: register load enables.
- `IncPC` out 1: ALU computes PC+1.
- `Read` out 1: MDR takes `Mdatain`.
- `reg_out` out 16: one-hot R0..R15 bus source enables.
- `reg_in` out 16: one-hot R0..R15 load enables.
- `op` out 5: ALU operation code.
- `running` out 1: high in T0..T6.
- `illegal` out 1: one-cycle pulse on an unrecognised opcode.

## Operation
- States: IDLE, T0..T6, HALTED. Reset state is IDLE.
- Outputs are a pure Moore decode of the state register plus IR fields. Every output is 0 in IDLE and HALTED, and every output is 0 after reset.
- IDLE: go to T0 when `run` = 1.
- T0: `PCout`, `MARin`, `IncPC`, `Zlowin`.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
- T2: `MDRout`, `IRin`. IR is valid from T3 onward.
- T3, by opcode class:
  - ALU class (opcodes 00000–01011): `reg_out[rb]`, `Yin`, then T4.
  - MUL (01111) / DIV (10000): same outputs as ALU class, then T4.
  - NOP (11010): no outputs, next state T0.
  - HALT (11011): next state HALTED.
  - Any other opcode: `illegal` = 1 for this cycle, next state T0.
- T4: `reg_out[rc]`, `op` = IR[31:27], `Zlowin`. `ZHighin` is also asserted for MUL/DIV. Then T5.
- T5:
  - ALU class: `Zlowout`, `reg_in[ra]`, then T0.
  - MUL/DIV: `Zlowout`, `LOin`, then T6.
- T6: `Zhighout`, `HIin`, then T0.
- HALTED: wait for `run` = 0, then go to IDLE. A level-held `run` therefore cannot restart a halted CPU.
- `op` = 0 in every state except T4.
- `reg_out` and `reg_in` are all-zero or exactly one-hot. ra = rb = rc is legal and handled with no special case.
- At most one bus source enable is high in any state.

## Timing
- Each T-state lasts exactly one `Clock` cycle.
- Outputs change only after the rising edge that enters a state. `data_path` registers capture on the rising edge that leaves the state.
- Instruction latency:
  - ALU class: 6 cycles (T0–T5).
  - MUL/DIV: 7 cycles.
  - NOP and illegal: 4 cycles.
- Back-to-back instructions follow with no idle cycle while running.
- `clear` asserted at any point, including mid-instruction, forces IDLE asynchronously. All outputs drop in the same delta, and the partially executed instruction is abandoned.
- `run` is sampled only in IDLE and HALTED. Deasserting `run` mid-instruction has no effect.

## Configuration
- Macro: `CONTROL_SEQ_MULDIV_EN`.
- Defined: MUL/DIV sequences T3–T6 exactly as above.
- Undefined:
  - Opcodes 01111/10000 take the illegal path: `illegal` pulse in T3, return to T0.
  - T6 and the `HIin`, `LOin`, `ZHighin` and `Zhighout` drive logic are removed; those outputs are tied to 0.

## Structure
- Package `cpu_pkg` holds:
  - the state enum;
  - opcode constants (`OP_SHRA` = 5'b00101, `OP_MUL`, `OP_DIV`, `OP_NOP`, `OP_HALT`);
  - IR field position constants.
- One sub-module, `reg_decode`: a 4-to-16 one-hot decoder with an enable. It is instantiated twice, once for `reg_out` and once for `reg_in`.

## Test plan
- **Reset:** `clear` = 1 mid-T4 → state IDLE and every output 0 in the same timestep. `clear` = 0 with `run` = 0 → stays in IDLE.
- **Fetch:** `run` = 1 from IDLE → over three successive cycles:
  - `PCout`+`MARin`+`IncPC`+`Zlowin`;
  - `Zlowout`+`PCin`+`Read`+`MDRin`;
  - `MDRout`+`IRin`.
- **SHRA R1,R3,R2** (IR = 0x28990000):
  - T3: `reg_out` = 0x0008, `Yin`.
  - T4: `reg_out` = 0x0004, `op` = 5'b00101, `Zlowin`.
  - T5: `Zlowout`, `reg_in` = 0x0002.
  - Then T0.
  - With `data_path` attached, R3 = 12 and R2 = 5 → R1 = 0.
- **MUL** (macro defined):
  - T4: `ZHighin` and `Zlowin` both high.
  - T5: `Zlowout`+`LOin`.
  - T6: `Zhighout`+`HIin`.
  - Macro undefined: same IR gives an `illegal` pulse in T3.
- **HALT / NOP:**
  - HALT (opcode 11011) → HALTED and outputs 0. `run` held 1 keeps HALTED. `run` 0 → IDLE. `run` 1 → T0.
  - NOP → T0 directly after T3.
- **Illegal:** opcode 11111 → `illegal` = 1 for exactly one cycle in T3, no register enables, next state T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the mini CPU control path: sequencer states, opcodes and IR field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [4:0] OP_SHRA     = 5'b00101;
  localparam logic [4:0] OP_ALU_LAST = 5'b01011;
  localparam logic [4:0] OP_MUL      = 5'b01111;
  localparam logic [4:0] OP_DIV      = 5'b10000;
  localparam logic [4:0] OP_NOP      = 5'b11010;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  // MUL/DIV fall into the illegal class when the multiply/divide path is not built.
  function automatic op_class_t classify(input logic [4:0] opcode, input logic muldiv_en);
    if (opcode <= OP_ALU_LAST) return CLS_ALU;
    if ((opcode == OP_MUL || opcode == OP_DIV) && muldiv_en) return CLS_MULDIV;
    if (opcode == OP_NOP) return CLS_NOP;
    if (opcode == OP_HALT) return CLS_HALT;
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/reg_decode.sv
// 4-to-16 one-hot register select decoder; output is all-zero when not enabled.
module reg_decode (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit driving data_path enables: fetch, decode, ALU and MUL/DIV execute.
// CONTROL_SEQ_MULDIV_EN builds the MUL/DIV sequence; without it those opcodes are illegal.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZHighin,
  output logic        Zlowin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic [4:0]  op,
  output logic        running,
  output logic        illegal,
  output state_t      state
);

`ifdef CONTROL_SEQ_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  state_t    state_next;
  op_class_t cls;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic [3:0] ro_sel;
  logic       ro_en, ri_en;
  logic       ir_unused;

  assign opcode    = IR[IR_OP_LSB +: 5];
  assign ra        = IR[IR_RA_LSB +: 4];
  assign rb        = IR[IR_RB_LSB +: 4];
  assign rc        = IR[IR_RC_LSB +: 4];
  assign cls       = classify(opcode, MULDIV_EN);
  assign ir_unused = ^IR[14:0];

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_next;
  end

  // Moore decode: outputs depend only on the state register and the latched IR.
  always_comb begin
    state_next = state;
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    ZHighin = 1'b0; Zlowin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    op = 5'd0; illegal = 1'b0;
    ro_en = 1'b0; ro_sel = rb; ri_en = 1'b0;
    running = (state != S_IDLE) && (state != S_HALTED);
    case (state)
      S_IDLE: if (run) state_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: begin
            ro_en = 1'b1; ro_sel = rb; Yin = 1'b1;
            state_next = S_T4;
          end
          CLS_NOP:  state_next = S_T0;
          CLS_HALT: state_next = S_HALTED;
          default: begin
            illegal = 1'b1;
            state_next = S_T0;
          end
        endcase
      end
      S_T4: begin
        ro_en = 1'b1; ro_sel = rc; op = opcode; Zlowin = 1'b1;
`ifdef CONTROL_SEQ_MULDIV_EN
        ZHighin = (cls == CLS_MULDIV);
`endif
        state_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
`ifdef CONTROL_SEQ_MULDIV_EN
        if (cls == CLS_MULDIV) begin
          LOin = 1'b1;
          state_next = S_T6;
        end else begin
          ri_en = 1'b1;
          state_next = S_T0;
        end
`else
        ri_en = 1'b1;
        state_next = S_T0;
`endif
      end
`ifdef CONTROL_SEQ_MULDIV_EN
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        state_next = S_T0;
      end
`endif
      S_HALTED: if (!run) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  reg_decode u_reg_out (.sel(ro_sel), .en(ro_en), .onehot(reg_out));
  reg_decode u_reg_in  (.sel(ra),     .en(ri_en), .onehot(reg_in));

endmodule
